// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard controller for a classic 5-stage in-order pipeline. It produces the
// forwarding selects for both decode-stage operands, the load-use stall and
// bubble, the redirect flush of IF/ID and a full-pipeline freeze while a data
// memory request is outstanding. A small FSM sequences multi-cycle load-use
// stalls, the optional second flush cycle and the memory wait. The memory wait
// remembers the interrupted state and its counter and resumes them afterwards.
//
// Parameters
//   REG_W        register-index width
//   LOAD_LAT     load-use stall cycles (1..3)
//   FLUSH_CYCLES cycles IF/ID is flushed after a redirect (1..2)
//   FWD_EN       1 = forwarding, 0 = stall-only operation
//   CNT_W        width of the hazard-cycle counter
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   id_rs, id_rt              decode-stage source registers
//   id_rs_used, id_rt_used    the corresponding source is actually read
//   ex_rd, ex_wen, ex_is_load EX destination, write enable, load flag
//   mem_rd, mem_wen           MEM destination, write enable
//   mem_req, dhit             MEM data request active / request complete
//   br_taken                  branch/jump redirect resolved this cycle
//   pc_stall, ifid_stall      hold PC / IF-ID register
//   idex_bubble               insert a NOP into ID/EX
//   ifid_flush                clear IF/ID
//   freeze                    hold every pipeline register
//   fwd_a, fwd_b              00 register file, 01 EX/MEM, 10 MEM/WB
//   hazard                    pc_stall | freeze | ifid_flush
//   state                     FSM state (RUN/LDSTALL/MEMWAIT/FLUSH)
//   stall_cnt                 saturating count of hazard cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int FWD_EN       = 1,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wen,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wen,
    input  logic             mem_req,
    input  logic             dhit,
    input  logic             br_taken,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             hazard,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_LDSTALL = 2'b01,
        S_MEMWAIT = 2'b10,
        S_FLUSH   = 2'b11
    } state_e;

    // Remaining LDSTALL cycles after the first (RUN) stall cycle.
    localparam logic [1:0]       LD_INIT = 2'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    state_e           saved_q, saved_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [1:0]       saved_cnt_q, saved_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic load_use, any_hit, miss;

    // Register 0 is hard-wired, so it never creates a dependency.
    assign ex_hit_a  = id_rs_used && ex_wen  && (id_rs == ex_rd)  && (id_rs != '0);
    assign ex_hit_b  = id_rt_used && ex_wen  && (id_rt == ex_rd)  && (id_rt != '0);
    assign mem_hit_a = id_rs_used && mem_wen && (id_rs == mem_rd) && (id_rs != '0);
    assign mem_hit_b = id_rt_used && mem_wen && (id_rt == mem_rd) && (id_rt != '0);
    assign load_use  = ex_is_load && (ex_hit_a || ex_hit_b);
    assign any_hit   = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b;
    assign miss      = mem_req && !dhit;

    // Next-state and combinational control outputs.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        freeze      = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        state_d     = state_q;
        cnt_d       = cnt_q;
        saved_d     = saved_q;
        saved_cnt_d = saved_cnt_q;

        if (RST) begin
            // Outputs stay quiet; the registers are cleared in the flop block.
            state_d = S_RUN;
        end else begin
            if (FWD_EN != 0) begin
                // A load result is not available in EX/MEM, so it falls to MEM/WB.
                if (ex_hit_a && !ex_is_load) begin
                    fwd_a = 2'b01;
                end else if (mem_hit_a) begin
                    fwd_a = 2'b10;
                end else begin
                    fwd_a = 2'b00;
                end
                if (ex_hit_b && !ex_is_load) begin
                    fwd_b = 2'b01;
                end else if (mem_hit_b) begin
                    fwd_b = 2'b10;
                end else begin
                    fwd_b = 2'b00;
                end
            end else begin
                fwd_a = 2'b00;
                fwd_b = 2'b00;
            end

            if (miss) begin
                // Outstanding data request wins over everything; br_taken is
                // dropped because the front end is frozen.
                freeze     = 1'b1;
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                state_d    = S_MEMWAIT;
                if (state_q != S_MEMWAIT) begin
                    saved_d     = state_q;
                    saved_cnt_d = cnt_q;
                end else begin
                    saved_d     = saved_q;
                    saved_cnt_d = saved_cnt_q;
                end
            end else if (br_taken) begin
                // Redirect kills the decode instruction, so no load-use stall.
                ifid_flush = 1'b1;
                cnt_d      = 2'b00;
                if (FLUSH_CYCLES == 2) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_RUN;
                end
            end else begin
                case (state_q)
                    S_RUN: begin
                        if ((FWD_EN != 0) && load_use) begin
                            pc_stall    = 1'b1;
                            ifid_stall  = 1'b1;
                            idex_bubble = 1'b1;
                            if (LOAD_LAT > 1) begin
                                state_d = S_LDSTALL;
                                cnt_d   = LD_INIT;
                            end else begin
                                state_d = S_RUN;
                            end
                        end else if ((FWD_EN == 0) && any_hit) begin
                            pc_stall    = 1'b1;
                            ifid_stall  = 1'b1;
                            idex_bubble = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                    S_LDSTALL: begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                        if (cnt_q <= 2'd1) begin
                            state_d = S_RUN;
                            cnt_d   = 2'b00;
                        end else begin
                            cnt_d = cnt_q - 2'd1;
                        end
                    end
                    S_MEMWAIT: begin
                        // dhit cycle: release the pipeline, resume next cycle.
                        state_d = saved_q;
                        cnt_d   = saved_cnt_q;
                    end
                    S_FLUSH: begin
                        ifid_flush = 1'b1;
                        state_d    = S_RUN;
                        cnt_d      = 2'b00;
                    end
                    default: begin
                        state_d = S_RUN;
                        cnt_d   = 2'b00;
                    end
                endcase
            end
        end

        hazard = pc_stall | freeze | ifid_flush;

        if (hazard && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, counters, saved context and hazard counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_RUN;
            saved_q     <= S_RUN;
            cnt_q       <= 2'b00;
            saved_cnt_q <= 2'b00;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            cnt_q       <= cnt_d;
            saved_cnt_q <= saved_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule
